// File: rtl/slope_sched.sv
// slope_sched: sequencer for the 9-point slope estimator.
// Paces sample intake with a decimated read strobe, clears the estimator on
// (re)start, counts the warm-up and flags when the estimator output is a
// slope computed purely from samples of the current run.
//
// Strobe semantics: read_en_o, clr_o and new_o are single-cycle pulses with
// no back-pressure; the estimator must accept every read_en_o pulse in the
// cycle it is high. valid_o is a level that stays high until the run ends.
module slope_sched #(
  parameter int DW   = 16,
  parameter int NPTS = 9,
  parameter int LAT  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable_i,
  input  logic [DW-1:0] dec_i,
  input  logic          hold_i,
  input  logic          restart_i,
  output logic          read_en_o,
  output logic          clr_o,
  output logic          valid_o,
  output logic          new_o,
  output logic [3:0]    fill_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [3:0] NPTS_F = 4'(NPTS);

  state_t          state;
  logic [DW-1:0]   dec_q;
  // cnt is the divider phase; read_en_o is high in exactly the cycles where
  // cnt == dec_q, so the strobe is registered one edge ahead of the wrap.
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   cnt_adv;
  logic            strobe_adv;
  logic [3:0]      fill_adv;
  logic            advance;
  // One bit per in-flight strobe whose estimator result will be valid.
  logic [LAT-1:0]  sr;
  logic [LAT-1:0]  sr_nxt;
  logic            sr_in;

  // Next divider phase and whether the strobe lands in the next cycle.
  always_comb begin
    cnt_adv    = (cnt == dec_q) ? '0 : cnt + DW'(1);
    strobe_adv = (cnt_adv == dec_q);
    fill_adv   = fill_o;
    if (strobe_adv && (fill_o != NPTS_F)) begin
      fill_adv = fill_o + 4'd1;
    end
  end

  // Divider runs through warm-up unconditionally; in RUN/HOLD it is gated
  // by hold_i so a hold freezes the phase and resumes where it stopped.
  always_comb begin
    advance = 1'b0;
    case (state)
      S_FILL:         advance = 1'b1;
      S_RUN, S_HOLD:  advance = !hold_i;
      default:        advance = 1'b0;
    endcase
  end

  // Latency pipeline: a strobe taken with a full window emerges as new_o
  // LAT cycles later. It keeps shifting in HOLD so in-flight results land.
  always_comb begin
    sr_in     = read_en_o && (fill_o == NPTS_F);
    sr_nxt    = '0;
    sr_nxt[0] = sr_in;
    for (int i = 1; i < LAT; i++) begin
      sr_nxt[i] = sr[i-1];
    end
  end

  // Sequencer state, divider, fill count, strobes and valid tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      dec_q     <= '0;
      cnt       <= '0;
      read_en_o <= 1'b0;
      clr_o     <= 1'b0;
      valid_o   <= 1'b0;
      fill_o    <= 4'd0;
      sr        <= '0;
    end else begin
      clr_o <= 1'b0;
      if (!enable_i) begin
        // Disable wins over everything; no clear pulse on the way out.
        state     <= S_IDLE;
        cnt       <= '0;
        read_en_o <= 1'b0;
        valid_o   <= 1'b0;
        fill_o    <= 4'd0;
        sr        <= '0;
      end else if ((state == S_IDLE) || restart_i) begin
        // Run start or restart: new divider, flush estimator and pipeline.
        // A strobe due from the old schedule is dropped; with a divider of
        // 0 the first strobe of the new run falls in the very next cycle.
        state     <= S_FILL;
        dec_q     <= dec_i;
        cnt       <= '0;
        clr_o     <= 1'b1;
        read_en_o <= (dec_i == '0);
        fill_o    <= (dec_i == '0) ? 4'd1 : 4'd0;
        valid_o   <= 1'b0;
        sr        <= '0;
      end else begin
        if (advance) begin
          cnt       <= cnt_adv;
          read_en_o <= strobe_adv;
          fill_o    <= fill_adv;
        end else begin
          read_en_o <= 1'b0;
        end
        sr      <= sr_nxt;
        valid_o <= valid_o | sr_nxt[LAT-1];
        case (state)
          S_FILL: begin
            if (strobe_adv && (fill_adv == NPTS_F)) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if (hold_i) begin
              state <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!hold_i) begin
              state <= S_RUN;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign new_o   = sr[LAT-1];
  assign state_o = state;

endmodule
